// File: rtl/pcileech_pcie_bar_rsp_if.sv
// AXI-stream style rx/tx TLP channels between the PCIe core and the BAR0 responder.
// slave = responder side, master = core/arbiter side.
interface pcileech_pcie_bar_rsp_if;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic        rx_last;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_bar0_hit;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  rx_data, rx_keep, rx_last, rx_valid, rx_bar0_hit, tx_ready,
    output rx_ready, tx_data, tx_keep, tx_last, tx_valid
  );
  modport master (
    output rx_data, rx_keep, rx_last, rx_valid, rx_bar0_hit, tx_ready,
    input  rx_ready, tx_data, tx_keep, tx_last, tx_valid
  );
endinterface

// File: rtl/pcileech_pcie_bar_rsp.sv
// BAR0 responder: 1-DW MRd/MWr against a 2^BAR_AW dword RAM, CplD on tx.
// Define PCILEECH_PCIE_BAR_RSP_UR_EN to answer malformed bar-hit MRds with a UR Cpl.
module pcileech_pcie_bar_rsp #(
  parameter int BAR_AW = 6
) (
  input  logic                   clk_pcie,
  input  logic                   rst,
  pcileech_pcie_bar_rsp_if.slave bus,
  input  logic [15:0]            completer_id,
  output logic [15:0]            drop_cnt
);

  typedef enum logic [2:0] {IDLE, HDR2, DRAIN, RD, CPL0, CPL1} state_t;
  state_t st, nxt;

  logic [2:0]  fmt_q, tc_q;
  logic [4:0]  typ_q;
  logic [1:0]  attr_q;
  logic [9:0]  len_q;
  logic [15:0] rid_q;
  logic [7:0]  tag_q;
  logic [3:0]  fbe_q;
  logic        hit_q, rsp_q, ur_q;
  logic [31:0] addr_q, rd_q;
  logic [31:0] ram [0:(1<<BAR_AW)-1];

  logic        rdy, acc, sup_rd, sup_wr, is_ur, drop_inc, hdr_acc;
  logic [11:0] bcnt;
  logic [1:0]  lo_be;

  assign sup_rd = hit_q && fmt_q == 3'b000 && typ_q == 5'd0 && len_q == 10'd1;
  assign sup_wr = hit_q && fmt_q == 3'b010 && typ_q == 5'd0 && len_q == 10'd1;
`ifdef PCILEECH_PCIE_BAR_RSP_UR_EN
  // any bar-hit MRd (3DW or 4DW) that is not a plain 1-DW read
  assign is_ur = hit_q && typ_q == 5'd0 && fmt_q[2:1] == 2'b00 && !sup_rd;
`else
  assign is_ur = 1'b0;
`endif
  assign hdr_acc = (st == HDR2) && acc;

  always_comb begin
    nxt      = st;
    rdy      = !rst && (st == IDLE || st == HDR2 || st == DRAIN);
    acc      = bus.rx_valid && rdy;
    drop_inc = 1'b0;
    case (st)
      IDLE: if (acc) begin
        if (bus.rx_last) drop_inc = 1'b1;
        else             nxt = HDR2;
      end
      HDR2: if (acc) begin
        drop_inc = !(sup_rd || sup_wr || is_ur);
        if (!bus.rx_last)          nxt = DRAIN;
        else if (sup_rd || is_ur)  nxt = RD;
        else                       nxt = IDLE;
      end
      DRAIN: if (acc && bus.rx_last) nxt = rsp_q ? RD : IDLE;
      RD:    nxt = CPL0;
      CPL0:  if (bus.tx_ready) nxt = CPL1;
      CPL1:  if (bus.tx_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign bus.rx_ready = rdy;

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      st       <= IDLE;
      drop_cnt <= '0;
      rsp_q    <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      st <= nxt;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (hdr_acc) begin
        rsp_q <= sup_rd || is_ur;
        ur_q  <= is_ur;
      end
    end
  end

  // header/address capture; no reset needed, only consumed after a full header
  always_ff @(posedge clk_pcie) begin
    if (st == IDLE && acc) begin
      fmt_q  <= bus.rx_data[31:29];
      typ_q  <= bus.rx_data[28:24];
      tc_q   <= bus.rx_data[22:20];
      attr_q <= bus.rx_data[13:12];
      len_q  <= bus.rx_data[9:0];
      rid_q  <= bus.rx_data[63:48];
      tag_q  <= bus.rx_data[47:40];
      fbe_q  <= bus.rx_data[35:32];
      hit_q  <= bus.rx_bar0_hit;
    end
    if (hdr_acc) addr_q <= bus.rx_data[31:0];
    if (st == RD) rd_q <= ram[addr_q[BAR_AW+1:2]];
  end

  always_ff @(posedge clk_pcie) begin
    if (hdr_acc && sup_wr)
      for (int i = 0; i < 4; i++)
        if (fbe_q[i]) ram[bus.rx_data[BAR_AW+1:2]][8*i +: 8] <= bus.rx_data[32+8*i +: 8];
  end

  always_comb begin
    casez (fbe_q)
      4'b1??1:                   bcnt = 12'd4;
      4'b01?1, 4'b1?10:          bcnt = 12'd3;
      4'b0011, 4'b0110, 4'b1100: bcnt = 12'd2;
      default:                   bcnt = 12'd1;
    endcase
    casez (fbe_q)
      4'b???1: lo_be = 2'd0;
      4'b??10: lo_be = 2'd1;
      4'b?100: lo_be = 2'd2;
      4'b1000: lo_be = 2'd3;
      default: lo_be = 2'd0;
    endcase
  end

  always_comb begin
    bus.tx_valid = 1'b0;
    bus.tx_last  = 1'b0;
    bus.tx_keep  = 8'h00;
    bus.tx_data  = 64'd0;
    case (st)
      CPL0: begin
        bus.tx_valid = 1'b1;
        bus.tx_keep  = 8'hFF;
        bus.tx_data  = {completer_id, (ur_q ? 3'b001 : 3'b000), 1'b0, (ur_q ? 12'd4 : bcnt),
                        (ur_q ? 3'b000 : 3'b010), 5'b01010, 1'b0, tc_q, 4'b0, 2'b00, attr_q,
                        2'b00, (ur_q ? 10'd0 : 10'd1)};
      end
      CPL1: begin
        bus.tx_valid = 1'b1;
        bus.tx_last  = 1'b1;
        bus.tx_keep  = ur_q ? 8'h0F : 8'hFF;
        bus.tx_data  = {(ur_q ? 32'd0 : rd_q), rid_q, tag_q, 1'b0, addr_q[6:2], lo_be};
      end
      default: ;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{bus.rx_keep, bus.rx_data, addr_q};

endmodule

// File: tb/tb_pcileech_pcie_bar_rsp.sv
// Self-checking bench for pcileech_pcie_bar_rsp: directed cases plus randomized MWr/MRd
// against a dword-array reference model.
module tb_pcileech_pcie_bar_rsp;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic        clk_pcie = 1'b0;
  logic        rst;
  logic [15:0] completer_id;
  logic [15:0] drop_cnt;

  pcileech_pcie_bar_rsp_if bus();

  pcileech_pcie_bar_rsp #(.BAR_AW(AW)) dut (
    .clk_pcie     (clk_pcie),
    .rst          (rst),
    .bus          (bus),
    .completer_id (completer_id),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk_pcie = ~clk_pcie;

  int          checks = 0;
  int          failures = 0;
  int          drops = 0;
  int          tx_beats = 0;
  logic [31:0] mem [DEPTH];

  always @(posedge clk_pcie) if (bus.tx_valid && bus.tx_ready) tx_beats <= tx_beats + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [31:0] fmt, typ, tc, attr, len, rid, tag, fbe);
    logic [31:0] d0, d1;
    d0 = (fmt << 29) | (typ << 24) | (tc << 20) | (attr << 12) | len;
    d1 = (rid << 16) | (tag << 8) | (fbe & 32'hF);
    return {d1, d0};
  endfunction

  task automatic send(input int nb, input logic [63:0] b0, b1, b2, input logic hit);
    int w;
    for (int i = 0; i < nb; i++) begin
      bus.rx_valid    = 1'b1;
      bus.rx_data     = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      bus.rx_keep     = 8'hFF;
      bus.rx_last     = (i == nb - 1);
      bus.rx_bar0_hit = hit;
      w = 0;
      while (!bus.rx_ready && w < 50) begin @(negedge clk_pcie); w++; end
      if (w >= 50) chk("rx_ready_wait", {63'd0, bus.rx_ready}, 64'd1);
      @(posedge clk_pcie);
      @(negedge clk_pcie);
    end
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
  endtask

  task automatic get_cpl(input string tag, input logic [63:0] e0, e1, input logic [7:0] k1,
                         input int stall);
    int w;
    logic [63:0] snap;
    bus.tx_ready = (stall == 0);
    w = 0;
    while (!bus.tx_valid && w < 20) begin @(negedge clk_pcie); w++; end
    chk({tag, "_latency"}, 64'(w), 64'd1);
    snap = bus.tx_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_pcie);
      chk({tag, "_stall_data"}, bus.tx_data, snap);
      chk({tag, "_stall_rdy"}, {62'd0, bus.rx_ready, bus.tx_valid}, 64'd1);
    end
    bus.tx_ready = 1'b1;
    chk({tag, "_b0"}, bus.tx_data, e0);
    chk({tag, "_b0_ctl"}, {54'd0, bus.tx_keep, bus.tx_last, bus.rx_ready}, {54'd0, 8'hFF, 1'b0, 1'b0});
    @(negedge clk_pcie);
    chk({tag, "_b1"}, bus.tx_data, e1);
    chk({tag, "_b1_ctl"}, {54'd0, bus.tx_keep, bus.tx_last, bus.tx_valid}, {54'd0, k1, 1'b1, 1'b1});
    @(negedge clk_pcie);
    chk({tag, "_done"}, {63'd0, bus.tx_valid}, 64'd0);
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [3:0] fbe, input logic [31:0] data);
    int idx;
    send(2, hdr(2, 0, 0, 0, 1, 32'h1234, 32'h11, {28'd0, fbe}), {data, addr}, 64'd0, 1'b1);
    idx = int'((addr >> 2) % DEPTH);
    for (int i = 0; i < 4; i++) if (fbe[i]) mem[idx][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic do_rd(input string tag, input logic [31:0] addr, input logic [3:0] fbe,
                       input logic [2:0] tc, input logic [1:0] attr, input logic [7:0] t,
                       input logic [15:0] rid, input int stall);
    int lo, hi, bc;
    logic [31:0] d0, d1, d2;
    send(2, hdr(0, 0, {29'd0, tc}, {30'd0, attr}, 1, {16'd0, rid}, {24'd0, t}, {28'd0, fbe}),
         {32'd0, addr}, 64'd0, 1'b1);
    lo = -1; hi = -1;
    for (int i = 0; i < 4; i++) if (fbe[i]) begin if (lo < 0) lo = i; hi = i; end
    bc = (lo < 0) ? 1 : hi - lo + 1;
    d0 = 32'h4A000001 | (32'(tc) << 20) | (32'(attr) << 12);
    d1 = (32'(completer_id) << 16) | 32'(bc);
    d2 = (32'(rid) << 16) | (32'(t) << 8) | (addr & 32'h7C) | ((lo < 0) ? 32'd0 : 32'(lo));
    get_cpl(tag, {d1, d0}, {mem[int'((addr >> 2) % DEPTH)], d2}, 8'hFF, stall);
  endtask

  initial begin
    int t0, w;
    logic [31:0] a, d;
    rst = 1'b1;
    completer_id = 16'h0200;
    bus.rx_valid = 1'b0; bus.rx_last = 1'b0; bus.rx_data = '0; bus.rx_keep = '0;
    bus.rx_bar0_hit = 1'b0; bus.tx_ready = 1'b1;

    repeat (2) @(negedge clk_pcie);
    chk("rst_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    chk("rst_tx", {bus.tx_valid, bus.tx_last, bus.tx_keep, bus.tx_data[53:0]}, 64'd0);
    chk("rst_tx_hi", {54'd0, bus.tx_data[63:54]}, 64'd0);
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    rst = 1'b0;
    @(negedge clk_pcie);
    chk("idle_rx_ready", {63'd0, bus.rx_ready}, 64'd1);

    for (int i = 0; i < DEPTH; i++) do_wr(32'(i * 4), 4'hF, $urandom);

    // worked example
    do_wr(32'h10, 4'hF, 32'hDEADBEEF);
    send(2, hdr(0, 0, 0, 0, 1, 32'h0100, 32'h05, 32'hF), {32'd0, 32'h10}, 64'd0, 1'b1);
    get_cpl("tp1", 64'h02000004_4A000001, 64'hDEADBEEF_01000510, 8'hFF, 0);

    // partial byte enables
    do_wr(32'h20, 4'hF, 32'h11223344);
    do_wr(32'h20, 4'b0011, 32'hAABBCCDD);
    send(2, hdr(0, 0, 0, 0, 1, 32'h0100, 32'h07, 32'h6), {32'd0, 32'h20}, 64'd0, 1'b1);
    get_cpl("pbe", 64'h02000002_4A000001, 64'h1122CCDD_01000721, 8'hFF, 0);

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      completer_id = 16'($urandom);
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(1, 0) == 1) do_wr(a, 4'($urandom), $urandom);
      else do_rd("rnd", a, 4'($urandom), 3'($urandom), 2'($urandom), 8'($urandom),
                 16'($urandom), ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : 0);
    end

    // backpressure
    do_rd("bp", 32'h20, 4'hF, 3'd5, 2'd2, 8'hA5, 16'hBEEF, 10);

    // address wrap
    do_rd("wrap", 32'h100, 4'hF, 3'd0, 2'd0, 8'h01, 16'h0001, 0);

    // unsupported / malformed traffic
    t0 = tx_beats;
    send(1, hdr(0, 0, 0, 0, 1, 1, 1, 32'hF), 64'd0, 64'd0, 1'b1);
    drops++;
    send(2, hdr(0, 0, 0, 0, 2, 32'h0303, 32'h33, 32'hF), {32'd0, 32'h40}, 64'd0, 1'b1);
`ifdef PCILEECH_PCIE_BAR_RSP_UR_EN
    get_cpl("ur_len", {(32'(completer_id) << 16) | 32'h2004, 32'h0A000000},
            {32'd0, 32'h03033340}, 8'h0F, 0);
    t0 = tx_beats;
`else
    drops++;
`endif
    send(2, hdr(2, 0, 0, 0, 1, 1, 2, 32'hF), {32'h5A5A5A5A, 32'h30}, 64'd0, 1'b0);
    drops++;
    send(3, hdr(1, 0, 0, 0, 1, 32'h0404, 32'h44, 32'hF), {32'h40, 32'h0}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`ifdef PCILEECH_PCIE_BAR_RSP_UR_EN
    get_cpl("ur_4dw", {(32'(completer_id) << 16) | 32'h2004, 32'h0A000000},
            {32'd0, 32'h04044400}, 8'h0F, 0);
    t0 = tx_beats;
`else
    drops++;
`endif
    repeat (4) @(negedge clk_pcie);
    chk("unsup_no_tx", 64'(tx_beats - t0), 64'd0);
    chk("unsup_drop", {48'd0, drop_cnt}, 64'(drops));
    do_rd("after_drop", 32'h30, 4'hF, 3'd1, 2'd1, 8'h3C, 16'h0100, 0);

    // reset during the second completion beat
    send(2, hdr(0, 0, 0, 0, 1, 32'h0100, 32'h09, 32'hF), {32'd0, 32'h10}, 64'd0, 1'b1);
    w = 0;
    while (!bus.tx_valid && w < 20) begin @(negedge clk_pcie); w++; end
    @(negedge clk_pcie);
    chk("rst_mid_in_cpl1", {63'd0, bus.tx_last}, 64'd1);
    bus.tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk_pcie);
    chk("rst_mid_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
    chk("rst_mid_drop", {48'd0, drop_cnt}, 64'd0);
    rst = 1'b0;
    drops = 0;
    bus.tx_ready = 1'b1;
    @(negedge clk_pcie);
    do_rd("post_rst", 32'h10, 4'hF, 3'd0, 2'd0, 8'h0A, 16'h0100, 0);
    do_rd("post_rst_pbe", 32'h20, 4'b1000, 3'd2, 2'd3, 8'h0B, 16'h0200, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
